// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC fetch unit: state encoding and parameter defaults.
package pc_fetch_pkg;

    // Fetch FSM encoding: FETCH=0, HOLD=1, ERR=2.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ERR   = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          TIMEOUT_DEFAULT  = 255;

    // A word fetch address must have its two low bits clear.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Counts FETCH cycles spent waiting for an acknowledge and flags the last allowed one.
module fetch_timer
    import pc_fetch_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Wide enough to hold TIMEOUT-1, the largest value the count ever reaches.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_q;

    // Wait counter: cleared outside FETCH, advances on every unacknowledged FETCH cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values and simulation matches the synthesized flops.
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch handshake: FETCH -> HOLD -> FETCH, with a sticky ERR state.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc_in,
    output logic [31:0] pc_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic        stall,
    output logic        err,
    output logic [31:0] retired
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  retired_q, retired_d;
    logic         valid_q, valid_d;
    logic         timer_clear, timer_enable, timer_expired;

    // The wait count restarts whenever we are not fetching, so it is zero on entry to FETCH.
    assign timer_clear  = (state_q != ST_FETCH);
    assign timer_enable = (state_q == ST_FETCH) && !imem_ack;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Next-state logic: capture on ack, advance on accept, trap on misalignment or timeout.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        retired_d = retired_q;

        unique case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else if (timer_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_HOLD: begin
                if (instr_accept && valid_q && !stall) begin
                    pc_d      = npc_in;
                    valid_d   = 1'b0;
                    retired_d = retired_q + 32'd1;
                    state_d   = is_word_aligned(npc_in) ? ST_FETCH : ST_ERR;
                end
            end
            ST_ERR: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_ERR;
            end
        endcase
    end

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == ST_FETCH);
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign err         = (state_q == ST_ERR);
    assign retired     = retired_q;

endmodule
